// File: rtl/vector_ram_stream.sv
// Vector RAM with full-vector / single-element writes and burst-streamed reads.
// Reads land directly in a two-entry output buffer (head register + skid register).
module vector_ram_stream #(
  parameter  int unsigned ELEM_W    = 32,
  parameter  int unsigned NUM_ELEMS = 32,
  parameter  int unsigned DEPTH     = 128,
  parameter  int unsigned ADDR_W    = 7,
  parameter  int unsigned IDX_W     = 5,
  localparam int unsigned VEC_W     = ELEM_W * NUM_ELEMS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] burst_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [VEC_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rem;

  logic [VEC_W-1:0]  skid_data;
  logic [ADDR_W-1:0] skid_addr;
  logic              skid_last;
  logic              skid_valid;

  logic              pop;
  logic              ld;
  logic              ld_last;
  logic [VEC_W-1:0]  rd_vec;

  assign pop     = out_valid & out_ready;
  // A read is issued only while fewer than two beats are held.
  assign ld      = (state == ISSUE) && !(out_valid && skid_valid);
  assign ld_last = (rem == (ADDR_W+1)'(1));
  assign rd_vec  = mem[rd_addr];

  // Storage array; not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_mode) begin
        mem[wr_addr][32'(wr_idx) * ELEM_W +: ELEM_W] <= wr_data[ELEM_W-1:0];
      end else begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Burst sequencing and output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      rem        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_last   <= 1'b0;
      skid_data  <= '0;
      skid_addr  <= '0;
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (burst_start && (burst_len != '0)) begin
            rd_addr <= burst_addr;
            rem     <= burst_len;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (ld) begin
            rd_addr <= (rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr + ADDR_W'(1);
            rem     <= rem - (ADDR_W+1)'(1);
            if (ld_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Head refills from skid first to keep address order; skid only fills while head stalls.
      if (pop || !out_valid) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_addr   <= skid_addr;
          out_last   <= skid_last;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (ld) begin
          out_data  <= rd_vec;
          out_addr  <= rd_addr;
          out_last  <= ld_last;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (ld) begin
        skid_data  <= rd_vec;
        skid_addr  <= rd_addr;
        skid_last  <= ld_last;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_ram_stream.sv
// Directed bench for vector_ram_stream: element-write table, burst streaming,
// backpressure, wrap, read/write collision and mid-burst reset.
module tb_vector_ram_stream;

  localparam int unsigned ELEM_W    = 32;
  localparam int unsigned NUM_ELEMS = 32;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned VEC_W     = ELEM_W * NUM_ELEMS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic              wr_mode;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0]  wr_idx;
  logic [VEC_W-1:0]  wr_data;
  logic              burst_start;
  logic [ADDR_W-1:0] burst_addr;
  logic [ADDR_W:0]   burst_len;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  always #5 clk = ~clk;

  vector_ram_stream #(
    .ELEM_W(ELEM_W), .NUM_ELEMS(NUM_ELEMS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_idx(wr_idx), .wr_data(wr_data),
    .burst_start(burst_start), .burst_addr(burst_addr), .burst_len(burst_len),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  logic [VEC_W-1:0] model [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       val;
    logic [IDX_W-1:0]  nb_idx;
    logic [31:0]       nb_exp;
  } elem_vec_t;

  elem_vec_t        ev [5];
  logic [VEC_W-1:0] p5;
  logic [VEC_W-1:0] fd;
  logic [VEC_W-1:0] new11;
  int               beats;
  int               cyc;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Element k of vector a is a*0x0100_0000 + k.
  function automatic logic [VEC_W-1:0] gen_vec(input int a);
    logic [VEC_W-1:0] v;
    for (int k = 0; k < int'(NUM_ELEMS); k++) v[k*ELEM_W +: ELEM_W] = 32'(a) * 32'h0100_0000 + 32'(k);
    return v;
  endfunction

  // All stimulus tasks start and end at a falling edge.
  task automatic wr_full(input logic [ADDR_W-1:0] a, input logic [VEC_W-1:0] d);
    wr_en = 1'b1; wr_mode = 1'b0; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic wr_elem(input logic [ADDR_W-1:0] a, input logic [IDX_W-1:0] idx, input logic [31:0] val);
    wr_en = 1'b1; wr_mode = 1'b1; wr_addr = a; wr_idx = idx;
    wr_data = {{(NUM_ELEMS-1){32'h5555_AAAA}}, val};
    @(negedge clk);
    wr_en = 1'b0; wr_mode = 1'b0;
    model[a][int'(idx)*ELEM_W +: ELEM_W] = val;
  endtask

  // Runs one burst, checking every accepted beat against the model. Optional stall,
  // a burst_start poke while busy, and a full write on a chosen cycle.
  task automatic run_burst(input logic [ADDR_W-1:0] a, input int len, input int stall_beat,
                           input int stall_n, input int poke_c, input int wr_c,
                           input logic [ADDR_W-1:0] wa, input logic [VEC_W-1:0] wd,
                           output logic [VEC_W-1:0] first_data);
    int beats_l, stalled, first_c, last_c, c;
    logic held_v, h_l;
    logic [VEC_W-1:0]  h_d;
    logic [ADDR_W-1:0] h_a, exp_a;
    beats_l = 0; stalled = 0; first_c = 0; last_c = 0; c = 0;
    held_v = 1'b0; h_l = 1'b0; h_d = '0; h_a = '0; exp_a = a; first_data = '0;
    burst_start = 1'b1; burst_addr = a; burst_len = (ADDR_W+1)'(len); out_ready = 1'b1;
    while (beats_l < len && c < 400) begin
      @(negedge clk);
      c++;
      burst_start = (c == poke_c);
      burst_addr  = ADDR_W'(50);
      burst_len   = (ADDR_W+1)'(3);
      wr_en = (c == wr_c); wr_mode = 1'b0; wr_addr = wa; wr_data = wd;
      if (held_v) begin
        check_vec($sformatf("hold data beat %0d", beats_l), out_data, h_d);
        check32($sformatf("hold addr beat %0d", beats_l), 32'(out_addr), 32'(h_a));
        check_b($sformatf("hold last beat %0d", beats_l), out_last, h_l);
      end
      if (out_valid && beats_l == stall_beat && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      held_v = out_valid && !out_ready;
      h_d = out_data; h_a = out_addr; h_l = out_last;
      if (out_valid && out_ready) begin
        check32($sformatf("addr beat %0d", beats_l), 32'(out_addr), 32'(exp_a));
        check_vec($sformatf("data beat %0d", beats_l), out_data, model[exp_a]);
        check_b($sformatf("last beat %0d", beats_l), out_last, beats_l == len - 1);
        if (beats_l == 0) begin
          first_c = c;
          first_data = out_data;
        end
        last_c = c;
        beats_l++;
        exp_a = exp_a + ADDR_W'(1);
      end
    end
    check32("beat count", 32'(beats_l), 32'(len));
    if (stall_n == 0) check32("no-bubble span", 32'(last_c - first_c), 32'(len - 1));
    @(negedge clk);
    burst_start = 1'b0; wr_en = 1'b0;
    check_b("busy after burst", busy, 1'b0);
    check_b("valid after burst", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ev[0] = '{ADDR_W'(5),   IDX_W'(3),  32'hDEAD_BEEF, IDX_W'(2),  32'h0000_0102};
    ev[1] = '{ADDR_W'(5),   IDX_W'(31), 32'h1234_5678, IDX_W'(30), 32'h0000_011E};
    ev[2] = '{ADDR_W'(9),   IDX_W'(17), 32'hCAFE_F00D, IDX_W'(16), 32'h0900_0010};
    ev[3] = '{ADDR_W'(9),   IDX_W'(0),  32'h0000_0001, IDX_W'(1),  32'h0900_0001};
    ev[4] = '{ADDR_W'(126), IDX_W'(0),  32'hFFFF_FFFF, IDX_W'(1),  32'h7E00_0001};
    for (int k = 0; k < int'(NUM_ELEMS); k++) p5[k*ELEM_W +: ELEM_W] = 32'(k) + 32'h100;
    new11 = {NUM_ELEMS{32'h0BAD_F00D}};

    rst_n = 1'b0; wr_en = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_idx = '0; wr_data = '0;
    burst_start = 1'b0; burst_addr = '0; burst_len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_b("reset busy", busy, 1'b0);
    check_b("reset valid", out_valid, 1'b0);
    check_b("reset last", out_last, 1'b0);
    check32("reset addr", 32'(out_addr), 32'h0);
    check_vec("reset data", out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 32; a++) wr_full(ADDR_W'(a), gen_vec(a));
    wr_full(ADDR_W'(126), gen_vec(126));
    wr_full(ADDR_W'(127), gen_vec(127));
    wr_full(ADDR_W'(5), p5);

    // Single-beat latency and busy fall.
    burst_start = 1'b1; burst_addr = ADDR_W'(5); burst_len = (ADDR_W+1)'(1); out_ready = 1'b1;
    @(negedge clk);
    burst_start = 1'b0;
    check_b("lat busy rises", busy, 1'b1);
    check_b("lat valid not early", out_valid, 1'b0);
    @(negedge clk);
    check_b("lat valid", out_valid, 1'b1);
    check_vec("lat data", out_data, p5);
    check32("lat addr", 32'(out_addr), 32'h5);
    check_b("lat last", out_last, 1'b1);
    check_b("lat busy held", busy, 1'b1);
    @(negedge clk);
    check_b("lat busy falls", busy, 1'b0);
    check_b("lat valid falls", out_valid, 1'b0);
    check_b("lat last falls", out_last, 1'b0);

    // Zero-length request is ignored.
    burst_start = 1'b1; burst_addr = ADDR_W'(3); burst_len = '0;
    @(negedge clk);
    burst_start = 1'b0;
    @(negedge clk);
    check_b("len0 busy", busy, 1'b0);
    check_b("len0 valid", out_valid, 1'b0);

    // Element-write table: target element and a neighbour.
    for (int i = 0; i < 5; i++) wr_elem(ev[i].addr, ev[i].idx, ev[i].val);
    for (int i = 0; i < 5; i++) begin
      run_burst(ev[i].addr, 1, -1, 0, 0, 0, '0, '0, fd);
      check32($sformatf("elem %0d target", i), fd[int'(ev[i].idx)*ELEM_W +: ELEM_W], ev[i].val);
      check32($sformatf("elem %0d neighbour", i), fd[int'(ev[i].nb_idx)*ELEM_W +: ELEM_W], ev[i].nb_exp);
    end

    // Wrap 126,127,0,1 at full rate.
    run_burst(ADDR_W'(126), 4, -1, 0, 0, 0, '0, '0, fd);

    // Backpressure on beat 2 plus an ignored burst_start while busy.
    run_burst(ADDR_W'(0), 8, 2, 3, 4, 0, '0, '0, fd);

    // Collision: addr 11 written on the cycle it is read; beat carries old data.
    run_burst(ADDR_W'(10), 4, -1, 0, 0, 2, ADDR_W'(11), new11, fd);
    model[11] = new11;
    run_burst(ADDR_W'(11), 1, -1, 0, 0, 0, '0, '0, fd);
    check_vec("collision new data", fd, new11);

    // Reset after three beats of a ten-beat burst.
    burst_start = 1'b1; burst_addr = ADDR_W'(20); burst_len = (ADDR_W+1)'(10); out_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      burst_start = 1'b0;
      if (out_valid) beats++;
    end
    check32("pre-reset beats", 32'(beats), 32'h3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_b("mid reset valid", out_valid, 1'b0);
    check_b("mid reset busy", busy, 1'b0);
    check_b("mid reset last", out_last, 1'b0);
    check32("mid reset addr", 32'(out_addr), 32'h0);
    check_vec("mid reset data", out_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_b($sformatf("post reset quiet %0d", i), out_valid | busy, 1'b0);
    end
    run_burst(ADDR_W'(20), 10, -1, 0, 0, 0, '0, '0, fd);
    run_burst(ADDR_W'(5), 1, -1, 0, 0, 0, '0, '0, fd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_ram_stream.md
Name: vector_ram_stream

Overview:
- Parametrised successor to the single-port vector RAM in the sparse accelerator.
- Stores DEPTH dense vectors of NUM_ELEMS elements, each ELEM_W bits wide.
- Writes can be full-vector or single-element (read-modify-write free).
- Reads are burst-streamed to the downstream multiply-accumulate path over a valid/ready handshake with full backpressure support.

Parameters:
- ELEM_W, 32, element width in bits
- NUM_ELEMS, 32, elements per vector (vector width VEC_W = ELEM_W*NUM_ELEMS = 1024)
- DEPTH, 128, number of vectors stored
- ADDR_W, 7, vector address width, clog2(DEPTH)
- IDX_W, 5, element index width, clog2(NUM_ELEMS)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, one write per cycle
- wr_mode  in  1  0 = full-vector write, 1 = single-element write
- wr_addr  in  ADDR_W  vector address for write
- wr_idx  in  IDX_W  element index; used only when wr_mode=1
- wr_data  in  VEC_W  write data; element write uses wr_data[ELEM_W-1:0]
- burst_start  in  1  request a read burst
- burst_addr  in  ADDR_W  first vector address of burst
- burst_len  in  ADDR_W+1  vectors in burst, 1..DEPTH
- busy  out  1  burst in progress
- out_valid  out  1  out_data holds a valid vector
- out_ready  in  1  downstream accepts the beat
- out_data  out  VEC_W  vector read data
- out_addr  out  ADDR_W  address of the vector in out_data
- out_last  out  1  final beat of the burst

Behaviour:
- Reset: busy=0, out_valid=0, out_last=0, out_data=0, out_addr=0; internal buffer emptied; address/count registers cleared. Memory contents are not reset and are preserved across reset.
- Reset is honoured mid-burst: the burst is abandoned immediately and no further beats are produced.
- Write, full vector: at the clk edge with wr_en=1 and wr_mode=0, mem[wr_addr] <= wr_data.
- Write, single element: with wr_en=1 and wr_mode=1, only element slice [wr_idx*ELEM_W +: ELEM_W] of mem[wr_addr] is updated; all other elements are unchanged.
- Writes are accepted in any state, including during a burst.
- Memory read is synchronous, 1 cycle.
- Read/write collision on the same address in the same cycle is read-first: the beat carries the pre-write data.
- Burst acceptance: burst_start=1, busy=0 and burst_len!=0 at an edge. busy rises after that edge.
- Ignored requests: burst_start while busy=1; burst_len=0 (busy stays 0, no beats).
- FSM states:
  - IDLE: waits for an accepted burst → ISSUE.
  - ISSUE: issues one RAM read per cycle while (buffered + in-flight) < 2; the address increments modulo DEPTH (127 → 0 wrap). After the last read issues → DRAIN.
  - DRAIN: waits until the buffer is empty and the final beat is accepted → IDLE; busy falls on that same edge.
- Output buffer: 2-entry skid/FIFO holding {data, addr, last}.
- out_valid=1 whenever the buffer is non-empty; a beat is consumed on an edge with out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_data, out_addr and out_last must hold stable.
- Latency: the first out_valid is asserted in the 2nd cycle after the accepting edge.
- Throughput: with out_ready held 1, exactly one beat per cycle, with no bubbles, until out_last.
- Exactly burst_len beats, in address order, with no loss or duplication under any out_ready pattern.
- out_last=1 only on the final beat.

Test Plan:
- Full write mem[5]=pattern with element k = k+0x100; burst addr 5, len 1, out_ready=1 → out_valid 2 cycles after start, out_data=pattern, out_addr=5, out_last=1, busy falls the cycle the beat is taken.
- Element write addr 5, idx 3, value 0xDEADBEEF, then burst addr 5 → element 3 = 0xDEADBEEF, elements 0-2 and 4-31 unchanged.
- Burst addr 126, len 4, out_ready=1 → out_addr 126, 127, 0, 1 on 4 consecutive cycles; out_last only on the beat with addr 1.
- Burst addr 0, len 8 with out_ready low for 3 cycles at beat 2 → beat 2 held stable; 8 beats total, addr 0-7, no duplicates; burst_start pulsed during the burst is ignored.
- Burst addr 10 while wr_en full-writes addr 11 on the cycle addr 11 is issued → beat for 11 returns old data; a later burst returns the new data.
- Assert rst_n=0 after 3 of 10 beats → out_valid and busy drop asynchronously; after release, a burst on previously written addresses returns intact data.
